// File: rtl/pwm_reg_arbiter_pkg.sv
// rtl/pwm_reg_arbiter_pkg.sv - shared types and defaults for the PWM register bus arbiter
package pwm_reg_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENG  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_e;

endpackage

// File: rtl/pwm_reg_arbiter_if.sv
// rtl/pwm_reg_arbiter_if.sv - engine req/gnt port of the PWM register bus arbiter
interface pwm_reg_arbiter_if
    import pwm_reg_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_gnt;
    logic [DW-1:0] e_rdata;
    logic          e_rvalid;
    logic          e_starve;

    modport master (
        output e_req, e_we, e_addr, e_wdata,
        input  e_gnt, e_rdata, e_rvalid, e_starve
    );

    modport slave (
        input  e_req, e_we, e_addr, e_wdata,
        output e_gnt, e_rdata, e_rvalid, e_starve
    );
endinterface

// File: rtl/pwm_reg_arbiter_sat_counter.sv
// rtl/pwm_reg_arbiter_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int MAX = 255,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);
    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

    assign at_max_o = (cnt_o == CNT_MAX);
endmodule

// File: rtl/pwm_reg_arbiter.sv
// rtl/pwm_reg_arbiter.sv - shares the PWM register bus between the I2C host and the internal engine
module pwm_reg_arbiter
    import pwm_reg_pkg::*;
#(
    parameter int AW            = DEF_AW,
    parameter int DW            = DEF_DW,
    parameter int HOLDOFF       = 4,
    parameter int MAX_WAIT      = 255,
    parameter bit LOCK_IN_FRAME = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_detected_i,
    input  logic          stop_detected_i,
    input  logic [AW-1:0] h_addr_i,
    input  logic          h_wr_en_i,
    input  logic          h_rd_en_i,
    input  logic [DW-1:0] h_wdata_i,
    output logic [DW-1:0] h_rdata_o,
    pwm_reg_arbiter_if.slave eng,
    output logic [AW-1:0] reg_addr_o,
    output logic          reg_wr_en_o,
    output logic          reg_rd_en_o,
    output logic [DW-1:0] reg_wdata_o,
    input  logic [DW-1:0] reg_rdata_i
);
    localparam int HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_LOAD);
    // With no hold-off a host write simply returns the FSM to IDLE.
    localparam arb_state_e WR_NEXT = (HOLDOFF > 0) ? ST_HOLD : ST_IDLE;

    arb_state_e        state;
    logic              frame_r;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rvalid_r;
    logic [DW-1:0]     rdata_r;

    logic host_act;
    logic lock;
    logic gnt;

    assign host_act = h_wr_en_i | h_rd_en_i;
    assign lock     = LOCK_IN_FRAME & frame_r;
    assign gnt      = (state == ST_ENG) & eng.e_req & ~host_act;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            frame_r  <= 1'b0;
            hold_cnt <= '0;
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else begin
            if (stop_detected_i) begin
                frame_r <= 1'b0;
            end else if (start_detected_i) begin
                frame_r <= 1'b1;
            end
            rvalid_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (h_wr_en_i) begin
                        state    <= WR_NEXT;
                        hold_cnt <= HOLD_INIT;
                    end else if (eng.e_req && !lock && !host_act) begin
                        state <= ST_ENG;
                    end
                end
                ST_ENG: begin
                    // The host preempts without stalling; the engine keeps its request and retries.
                    if (host_act) begin
                        state    <= h_wr_en_i ? WR_NEXT : ST_IDLE;
                        hold_cnt <= HOLD_INIT;
                    end else if (!eng.e_req) begin
                        state <= ST_IDLE;
                    end else if (eng.e_we) begin
                        state <= ST_IDLE;
                    end else begin
                        rdata_r  <= reg_rdata_i;
                        rvalid_r <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (h_wr_en_i) begin
                        state    <= WR_NEXT;
                        hold_cnt <= HOLD_INIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (h_wr_en_i) begin
                        hold_cnt <= HOLD_INIT;
                    end else if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (eng.e_req & ~gnt),
        .clr_i    (~eng.e_req | gnt),
        .cnt_o    (),
        .at_max_o (eng.e_starve)
    );

    assign reg_addr_o  = host_act ? h_addr_i  : (gnt ? eng.e_addr  : '0);
    assign reg_wdata_o = host_act ? h_wdata_i : (gnt ? eng.e_wdata : '0);
    assign reg_wr_en_o = ~rst_i & (h_wr_en_i | (gnt &  eng.e_we));
    assign reg_rd_en_o = ~rst_i & (h_rd_en_i | (gnt & ~eng.e_we));

    assign h_rdata_o    = reg_rdata_i;
    assign eng.e_gnt    = gnt;
    assign eng.e_rdata  = rdata_r;
    assign eng.e_rvalid = rvalid_r;
endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// tb/tb_pwm_reg_arbiter.sv - directed self-checking bench for pwm_reg_arbiter
module tb_pwm_reg_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_det;
    logic          stop_det;
    logic [AW-1:0] h_addr;
    logic          h_wr_en;
    logic          h_rd_en;
    logic [DW-1:0] h_wdata;
    logic [DW-1:0] h_rdata;
    logic [AW-1:0] reg_addr;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic any_g;
    logic s254;
    logic s255;

    pwm_reg_arbiter_if #(.AW(AW), .DW(DW)) eif ();

    pwm_reg_arbiter #(
        .AW            (AW),
        .DW            (DW),
        .HOLDOFF       (4),
        .MAX_WAIT      (255),
        .LOCK_IN_FRAME (1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_detected_i (start_det),
        .stop_detected_i  (stop_det),
        .h_addr_i         (h_addr),
        .h_wr_en_i        (h_wr_en),
        .h_rd_en_i        (h_rd_en),
        .h_wdata_i        (h_wdata),
        .h_rdata_o        (h_rdata),
        .eng              (eif.slave),
        .reg_addr_o       (reg_addr),
        .reg_wr_en_o      (reg_wr_en),
        .reg_rd_en_o      (reg_rd_en),
        .reg_wdata_o      (reg_wdata),
        .reg_rdata_i      (reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; start_det = 1'b0; stop_det = 1'b0;
        h_addr = '0; h_wr_en = 1'b0; h_rd_en = 1'b0; h_wdata = '0;
        reg_rdata = 16'hBEEF;
        eif.e_req = 1'b0; eif.e_we = 1'b0; eif.e_addr = '0; eif.e_wdata = '0;

        // reset: outputs quiet, bus enables forced low even with a host write
        @(negedge clk); h_wr_en = 1'b1; h_addr = 8'h55;
        #1;
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_gnt", eif.e_gnt, 0);
        chk("rst_rvalid", eif.e_rvalid, 0);
        chk("rst_starve", eif.e_starve, 0);
        chk("rst_rdata", eif.e_rdata, 0);
        @(negedge clk); h_wr_en = 1'b0; h_addr = '0; rst = 1'b0;

        // engine write: grant one cycle after the request
        @(negedge clk); eif.e_req = 1'b1; eif.e_we = 1'b1; eif.e_addr = 8'h06; eif.e_wdata = 16'h1234;
        #1 chk("ew_no_gnt_idle", eif.e_gnt, 0);
        @(negedge clk); #1;
        chk("ew_gnt", eif.e_gnt, 1);
        chk("ew_wr_en", reg_wr_en, 1);
        chk("ew_rd_en", reg_rd_en, 0);
        chk("ew_addr", reg_addr, 8'h06);
        chk("ew_wdata", reg_wdata, 16'h1234);
        @(negedge clk); eif.e_req = 1'b0;
        #1 chk("ew_gnt_after_drop", eif.e_gnt, 0);
        @(negedge clk); #1 chk("ew_bus_idle", reg_wr_en, 0);

        // host preemption in ENG, then hold-off of 4
        @(negedge clk); eif.e_req = 1'b1; eif.e_we = 1'b1; eif.e_addr = 8'h20; eif.e_wdata = 16'h5555;
        @(negedge clk); h_wr_en = 1'b1; h_addr = 8'h10; h_wdata = 16'h0ABC;
        #1;
        chk("hp_addr", reg_addr, 8'h10);
        chk("hp_wdata", reg_wdata, 16'h0ABC);
        chk("hp_wr_en", reg_wr_en, 1);
        chk("hp_gnt", eif.e_gnt, 0);
        any_g = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                h_wr_en = 1'b0; h_addr = '0; h_wdata = '0;
            end
            #1;
            if (k < 6) any_g = any_g | eif.e_gnt;
        end
        chk("hp_no_early_gnt", any_g, 0);
        chk("hp_gnt_at_6", eif.e_gnt, 1);
        chk("hp_eng_addr", reg_addr, 8'h20);
        chk("hp_eng_wdata", reg_wdata, 16'h5555);
        @(negedge clk); eif.e_req = 1'b0;

        // engine read, host read during the response cycle
        @(negedge clk); eif.e_req = 1'b1; eif.e_we = 1'b0; eif.e_addr = 8'h08; reg_rdata = 16'hBEEF;
        @(negedge clk); #1;
        chk("er_gnt", eif.e_gnt, 1);
        chk("er_rd_en", reg_rd_en, 1);
        chk("er_wr_en", reg_wr_en, 0);
        chk("er_addr", reg_addr, 8'h08);
        @(negedge clk); eif.e_req = 1'b0; h_rd_en = 1'b1; h_addr = 8'h33; reg_rdata = 16'h7777;
        #1;
        chk("er_rvalid", eif.e_rvalid, 1);
        chk("er_rdata", eif.e_rdata, 16'hBEEF);
        chk("er_h_rdata", h_rdata, 16'h7777);
        chk("er_h_addr", reg_addr, 8'h33);
        chk("er_h_rd_en", reg_rd_en, 1);
        @(negedge clk); h_rd_en = 1'b0; h_addr = '0;
        #1 chk("er_rvalid_pulse", eif.e_rvalid, 0);

        // host read in IDLE does not start a hold-off
        @(negedge clk); eif.e_req = 1'b1; eif.e_we = 1'b1; eif.e_addr = 8'h0C; eif.e_wdata = 16'h00C0;
        h_rd_en = 1'b1; h_addr = 8'h40;
        #1;
        chk("hr_gnt0", eif.e_gnt, 0);
        chk("hr_addr", reg_addr, 8'h40);
        @(negedge clk); h_rd_en = 1'b0; h_addr = '0;
        #1 chk("hr_gnt1", eif.e_gnt, 0);
        @(negedge clk); #1;
        chk("hr_gnt2", eif.e_gnt, 1);
        chk("hr_eng_addr", reg_addr, 8'h0C);
        @(negedge clk); eif.e_req = 1'b0;

        // frame lock and starvation
        @(negedge clk); start_det = 1'b1;
        @(negedge clk); start_det = 1'b0;
        eif.e_req = 1'b1; eif.e_we = 1'b1; eif.e_addr = 8'h0E; eif.e_wdata = 16'h00FF;
        #1 any_g = eif.e_gnt;
        s254 = 1'b1; s255 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk); #1;
            any_g = any_g | eif.e_gnt;
            if (k == 254) s254 = eif.e_starve;
            if (k == 255) s255 = eif.e_starve;
        end
        chk("fl_no_gnt", any_g, 0);
        chk("fl_starve_254", s254, 0);
        chk("fl_starve_255", s255, 1);
        @(negedge clk); stop_det = 1'b1;
        #1 chk("fl_gnt_stop", eif.e_gnt, 0);
        @(negedge clk); stop_det = 1'b0;
        #1 chk("fl_gnt_stop1", eif.e_gnt, 0);
        @(negedge clk); #1;
        chk("fl_gnt_stop2", eif.e_gnt, 1);
        chk("fl_addr", reg_addr, 8'h0E);
        chk("fl_starve_at_gnt", eif.e_starve, 1);
        @(negedge clk); eif.e_req = 1'b0;
        #1 chk("fl_starve_clear", eif.e_starve, 0);

        // asynchronous reset during an engine read
        @(negedge clk); eif.e_req = 1'b1; eif.e_we = 1'b0; eif.e_addr = 8'h08; reg_rdata = 16'h1111;
        @(negedge clk); #1;
        chk("rr_gnt", eif.e_gnt, 1);
        chk("rr_rd_en", reg_rd_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("rr_gnt_rst", eif.e_gnt, 0);
        chk("rr_rd_en_rst", reg_rd_en, 0);
        chk("rr_rvalid_rst", eif.e_rvalid, 0);
        @(negedge clk); eif.e_req = 1'b0; rst = 1'b0;
        #1;
        chk("rr_rvalid_rel", eif.e_rvalid, 0);
        chk("rr_rdata_rel", eif.e_rdata, 0);
        @(negedge clk); eif.e_req = 1'b1; eif.e_we = 1'b1; eif.e_addr = 8'h03; eif.e_wdata = 16'h0003;
        #1 chk("rr_idle_gnt0", eif.e_gnt, 0);
        @(negedge clk); #1;
        chk("rr_idle_gnt1", eif.e_gnt, 1);
        chk("rr_idle_rvalid", eif.e_rvalid, 0);
        @(negedge clk); eif.e_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
